// File: rtl/input_bus.sv
// input_bus: injects external spikes into the west edge of the core grid.
//
// Absolute (core x, core y, axon, tick) spikes arrive over a valid/ready
// handshake. Each spike is converted to a relative-routed packet (dx, dy
// measured from the bus position x = -1, y = BUS_ROW). Packets are held in a
// first-word-fall-through FIFO that the column-0 router drains with the
// grid's empty/ren protocol.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   in_core_x/y        destination core column/row (unsigned)
//   in_axon, in_tick   destination axon and tick offset
//   in_valid/in_ready  spike handshake; in_ready = FIFO not full
//   dout_east          FIFO head packet (router din_west)
//   empty_out_east     FIFO empty (router empty_in_west)
//   ren_in_east        router pop (router ren_out_west)
//   tick               one-cycle tick pulse
//   inject_count       packets popped since the last tick (wraps at 16 bits)
//   drained            FIFO empty, for the tick controller
//   range_error        sticky: an out-of-range spike was dropped
module input_bus #(
    parameter int PACKET_WIDTH = 30,
    parameter int DX_MSB       = 29,
    parameter int DX_LSB       = 21,
    parameter int DY_MSB       = 20,
    parameter int DY_LSB       = 12,
    parameter int NUM_AXONS    = 256,
    parameter int NUM_TICKS    = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUS_ROW      = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DX_MSB-DX_LSB:0]           in_core_x,
    input  logic [DY_MSB-DY_LSB:0]           in_core_y,
    input  logic [$clog2(NUM_AXONS)-1:0]     in_axon,
    input  logic [$clog2(NUM_TICKS)-1:0]     in_tick,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [PACKET_WIDTH-1:0]          dout_east,
    output logic                             empty_out_east,
    input  logic                             ren_in_east,
    input  logic                             tick,
    output logic [15:0]                      inject_count,
    output logic                             drained,
    output logic                             range_error
);

    localparam int DXW = DX_MSB - DX_LSB + 1;
    localparam int DYW = DY_MSB - DY_LSB + 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [DYW:0]  BUS_ROW_EXT = (DYW + 1)'(BUS_ROW);
    localparam logic [DXW:0]  DX_ONE      = (DXW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE     = PW'(1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);

    logic [PACKET_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr_r;
    logic [PW-1:0]           wr_ptr_r;
    logic [CW-1:0]           count_r;
    logic [15:0]             inject_count_r;
    logic                    range_error_r;

    logic [DXW:0]            dx_s;
    logic [DYW:0]            dy_s;
    logic                    in_range_s;
    logic [PACKET_WIDTH-1:0] pkt_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    accept_s;
    logic                    wr_s;
    logic                    pop_s;

    // Relative-address conversion and range test, one bit wider than the fields.
    always_comb begin
        dx_s       = {1'b0, in_core_x} + DX_ONE;
        dy_s       = {1'b0, in_core_y} - BUS_ROW_EXT;
        // dx is never negative, so it fits only if both top bits are clear;
        // dy fits its signed field when its two top bits agree.
        in_range_s = (dx_s[DXW:DXW-1] == 2'b00) && (dy_s[DYW] == dy_s[DYW-1]);
        pkt_s      = {dx_s[DXW-1:0], dy_s[DYW-1:0], in_axon, in_tick};
    end

    // Handshake and FIFO control decode; ready depends only on stored state.
    always_comb begin
        full_s   = (count_r == CNT_FULL);
        empty_s  = (count_r == {CW{1'b0}});
        accept_s = in_valid && !full_s;
        wr_s     = accept_s && in_range_s;
        pop_s    = ren_in_east && !empty_s;
    end

    // FIFO storage, pointers and occupancy; reset clears storage so head reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {PACKET_WIDTH{1'b0}};
            end
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= pkt_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Per-tick injection counter; a pop coinciding with tick counts toward the new tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inject_count_r <= 16'd0;
        end else if (tick) begin
            inject_count_r <= pop_s ? 16'd1 : 16'd0;
        end else if (pop_s) begin
            inject_count_r <= inject_count_r + 16'd1;
        end else begin
            inject_count_r <= inject_count_r;
        end
    end

    // Sticky flag for spikes dropped because their destination cannot be encoded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            range_error_r <= 1'b0;
        end else if (accept_s && !in_range_s) begin
            range_error_r <= 1'b1;
        end else begin
            range_error_r <= range_error_r;
        end
    end

    // Output drive: all taken directly from stored state.
    always_comb begin
        in_ready       = !full_s;
        empty_out_east = empty_s;
        drained        = empty_s;
        dout_east      = mem_r[rd_ptr_r];
        inject_count   = inject_count_r;
        range_error    = range_error_r;
    end

endmodule

// File: tb/tb_input_bus.sv
// tb_input_bus: self-checking bench for input_bus. Two instances share the
// stimulus, one at bus row 0 and one at bus row 5, and each is compared against
// a queue-based reference model built from the packet/range rules.
module tb_input_bus;

    logic        clk;
    logic        reset;
    logic [8:0]  in_core_x;
    logic [8:0]  in_core_y;
    logic [7:0]  in_axon;
    logic [3:0]  in_tick;
    logic        in_valid;
    logic        ren_in_east;
    logic        tick;

    logic        rdy0, emp0, drn0, rerr0;
    logic [29:0] dout0;
    logic [15:0] inj0;
    logic        rdy5, emp5, drn5, rerr5;
    logic [29:0] dout5;
    logic [15:0] inj5;

    int errors;
    int checks;

    // Reference model state for each instance
    logic [29:0] mq0[$];
    logic [29:0] mq5[$];
    int          minj0, minj5;
    bit          mrerr0, mrerr5;

    input_bus #(.BUS_ROW(0)) dut0 (
        .clk(clk), .reset(reset), .in_core_x(in_core_x), .in_core_y(in_core_y),
        .in_axon(in_axon), .in_tick(in_tick), .in_valid(in_valid), .in_ready(rdy0),
        .dout_east(dout0), .empty_out_east(emp0), .ren_in_east(ren_in_east),
        .tick(tick), .inject_count(inj0), .drained(drn0), .range_error(rerr0)
    );

    input_bus #(.BUS_ROW(5)) dut5 (
        .clk(clk), .reset(reset), .in_core_x(in_core_x), .in_core_y(in_core_y),
        .in_axon(in_axon), .in_tick(in_tick), .in_valid(in_valid), .in_ready(rdy5),
        .dout_east(dout5), .empty_out_east(emp5), .ren_in_east(ren_in_east),
        .tick(tick), .inject_count(inj5), .drained(drn5), .range_error(rerr5)
    );

    always #5 clk = ~clk;

    function automatic bit in_rng(int x, int y, int row);
        int dx, dy;
        dx = x + 1;
        dy = y - row;
        return (dx <= 255) && (dy >= -256) && (dy <= 255);
    endfunction

    function automatic logic [29:0] mk(int x, int y, int a, int t, int row);
        int dx, dy;
        dx = x + 1;
        dy = y - row;
        return {9'(dx), 9'(dy), 8'(a), 4'(t)};
    endfunction

    // One clock: drive inputs, take the edge, advance both models.
    task automatic step(input bit v, input int x, input int y, input int a, input int t,
                        input bit r, input bit tk);
        bit acc0, acc5, pop0, pop5;
        acc0 = v && (mq0.size() < 8);
        acc5 = v && (mq5.size() < 8);
        pop0 = r && (mq0.size() > 0);
        pop5 = r && (mq5.size() > 0);
        in_valid = v; in_core_x = 9'(x); in_core_y = 9'(y);
        in_axon = 8'(a); in_tick = 4'(t); ren_in_east = r; tick = tk;
        @(posedge clk);
        #1;
        if (pop0) void'(mq0.pop_front());
        if (pop5) void'(mq5.pop_front());
        if (acc0) begin
            if (in_rng(x, y, 0)) mq0.push_back(mk(x, y, a, t, 0));
            else mrerr0 = 1'b1;
        end
        if (acc5) begin
            if (in_rng(x, y, 5)) mq5.push_back(mk(x, y, a, t, 5));
            else mrerr5 = 1'b1;
        end
        if (tk) begin
            minj0 = pop0 ? 1 : 0;
            minj5 = pop5 ? 1 : 0;
        end else begin
            if (pop0) minj0 = (minj0 + 1) % 65536;
            if (pop5) minj5 = (minj5 + 1) % 65536;
        end
        in_valid = 1'b0; ren_in_east = 1'b0; tick = 1'b0;
    endtask

    task automatic clear_model();
        mq0.delete(); mq5.delete();
        minj0 = 0; minj5 = 0; mrerr0 = 1'b0; mrerr5 = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy0); end
        checks++; if (emp0 !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", emp0); end
        checks++; if (drn0 !== 1'b1) begin errors++; $display("FAIL reset_drained: got %b want 1", drn0); end
        checks++; if (dout0 !== 30'd0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout0); end
        checks++; if (inj0 !== 16'd0) begin errors++; $display("FAIL reset_inject: got %0d want 0", inj0); end
        checks++; if (rerr0 !== 1'b0) begin errors++; $display("FAIL reset_rerr: got %b want 0", rerr0); end
    endtask

    task automatic test_basic();
        logic [29:0] exp;
        exp = {9'd3, 9'd3, 8'h15, 4'd4};
        step(1'b1, 2, 3, 8'h15, 4, 1'b0, 1'b0);
        checks++; if (emp0 !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b want 0", emp0); end
        checks++; if (dout0 !== exp) begin errors++; $display("FAIL basic_dout: got %h want %h", dout0, exp); end
        checks++; if (dout5 !== mq5[0]) begin errors++; $display("FAIL basic_dout_row5: got %h want %h", dout5, mq5[0]); end
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        checks++; if (emp0 !== 1'b1) begin errors++; $display("FAIL basic_pop_empty: got %b want 1", emp0); end
        checks++; if (inj0 !== 16'd1) begin errors++; $display("FAIL basic_inject: got %0d want 1", inj0); end
    endtask

    task automatic test_bus_row_range();
        step(1'b1, 0, 2, 1, 1, 1'b0, 1'b0);
        checks++; if (dout5[20:12] !== 9'h1FD) begin errors++; $display("FAIL row5_dy: got %h want 1fd", dout5[20:12]); end
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 255, 0, 0, 0, 1'b0, 1'b0);
        checks++; if (rerr0 !== 1'b1) begin errors++; $display("FAIL range_err: got %b want 1", rerr0); end
        checks++; if (emp0 !== 1'b1) begin errors++; $display("FAIL range_empty: got %b want 1", emp0); end
        checks++; if (rerr5 !== 1'b1) begin errors++; $display("FAIL range_err_row5: got %b want 1", rerr5); end
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        checks++; if (rerr0 !== 1'b1) begin errors++; $display("FAIL range_sticky: got %b want 1", rerr0); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b want 1", i, rdy0); end
            step(1'b1, 10 + i, i, i, i, 1'b0, 1'b0);
        end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", rdy0); end
        step(1'b1, 18, 8, 8, 8, 1'b0, 1'b0);
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL full_held: got %b want 0", rdy0); end
        checks++; if (dout0 !== mq0[0]) begin errors++; $display("FAIL full_head: got %h want %h", dout0, mq0[0]); end
        step(1'b1, 18, 8, 8, 8, 1'b1, 1'b0);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", rdy0); end
        step(1'b1, 18, 8, 8, 8, 1'b0, 1'b0);
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL full_again: got %b want 0", rdy0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (dout0 !== mq0[0]) begin errors++; $display("FAIL full_order_%0d: got %h want %h", i, dout0, mq0[0]); end
            if (i == 7) begin
                checks++; if (dout0[29:21] !== 9'd19) begin errors++; $display("FAIL full_ninth_last: got %0d want 19", dout0[29:21]); end
            end
            step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        end
        checks++; if (emp0 !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", emp0); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) step(1'b1, 30 + i, 40 + i, i, i, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 50 + i, 60 + i, 100 + i, i, 1'b1, 1'b0);
            checks++; if (dout0 !== mq0[0]) begin errors++; $display("FAIL stream_order_%0d: got %h want %h", i, dout0, mq0[0]); end
        end
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        checks++; if (emp0 !== 1'b0) begin errors++; $display("FAIL stream_occ_two_left: got %b want 0", emp0); end
        checks++; if (dout0 !== mq0[0]) begin errors++; $display("FAIL stream_last: got %h want %h", dout0, mq0[0]); end
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        checks++; if (emp0 !== 1'b1) begin errors++; $display("FAIL stream_occ_three: got %b want 1", emp0); end
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        checks++; if (emp0 !== 1'b1) begin errors++; $display("FAIL ren_empty_flag: got %b want 1", emp0); end
        checks++; if (inj0 !== 16'(minj0)) begin errors++; $display("FAIL ren_empty_count: got %0d want %0d", inj0, minj0); end
        step(1'b1, 77, 7, 7, 7, 1'b0, 1'b0);
        checks++; if (dout0 !== mq0[0]) begin errors++; $display("FAIL ren_empty_ptr: got %h want %h", dout0, mq0[0]); end
    endtask

    task automatic test_tick();
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        checks++; if (inj0 !== 16'd1) begin errors++; $display("FAIL tick_with_pop: got %0d want 1", inj0); end
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        checks++; if (inj0 !== 16'd0) begin errors++; $display("FAIL tick_alone: got %0d want 0", inj0); end
    endtask

    task automatic test_wrap();
        step(1'b1, 1, 1, 1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, i % 200, i % 100, i % 256, i % 16, 1'b1, (i == 0));
        end
        checks++; if (inj0 !== 16'd0) begin errors++; $display("FAIL wrap_count: got %0d want 0", inj0); end
        checks++; if (inj5 !== 16'(minj5)) begin errors++; $display("FAIL wrap_count_row5: got %0d want %0d", inj5, minj5); end
    endtask

    task automatic test_async_reset();
        while (mq0.size() < 5) step(1'b1, 3, 3, 3, 3, 1'b0, 1'b0);
        checks++; if (rerr0 !== 1'b1) begin errors++; $display("FAIL areset_pre_rerr: got %b want 1", rerr0); end
        reset = 1'b1;
        #1;
        checks++; if (emp0 !== 1'b1) begin errors++; $display("FAIL areset_empty: got %b want 1", emp0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b want 1", rdy0); end
        checks++; if (rerr0 !== 1'b0) begin errors++; $display("FAIL areset_rerr: got %b want 0", rerr0); end
        checks++; if (dout0 !== 30'd0) begin errors++; $display("FAIL areset_dout: got %h want 0", dout0); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            checks++; if (rdy0 !== (mq0.size() < 8)) begin errors++; $display("FAIL rnd_ready0_%0d: got %b", i, rdy0); end
            checks++; if (rdy5 !== (mq5.size() < 8)) begin errors++; $display("FAIL rnd_ready5_%0d: got %b", i, rdy5); end
            checks++; if (emp0 !== (mq0.size() == 0)) begin errors++; $display("FAIL rnd_empty0_%0d: got %b", i, emp0); end
            checks++; if (drn5 !== (mq5.size() == 0)) begin errors++; $display("FAIL rnd_drained5_%0d: got %b", i, drn5); end
            if (mq0.size() > 0) begin
                checks++; if (dout0 !== mq0[0]) begin errors++; $display("FAIL rnd_dout0_%0d: got %h want %h", i, dout0, mq0[0]); end
            end
            if (mq5.size() > 0) begin
                checks++; if (dout5 !== mq5[0]) begin errors++; $display("FAIL rnd_dout5_%0d: got %h want %h", i, dout5, mq5[0]); end
            end
            checks++; if (inj0 !== 16'(minj0)) begin errors++; $display("FAIL rnd_inj0_%0d: got %0d want %0d", i, inj0, minj0); end
            checks++; if (inj5 !== 16'(minj5)) begin errors++; $display("FAIL rnd_inj5_%0d: got %0d want %0d", i, inj5, minj5); end
            checks++; if (rerr0 !== mrerr0) begin errors++; $display("FAIL rnd_rerr0_%0d: got %b want %b", i, rerr0, mrerr0); end
            checks++; if (rerr5 !== mrerr5) begin errors++; $display("FAIL rnd_rerr5_%0d: got %b want %b", i, rerr5, mrerr5); end
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 254)),
                 int'($urandom_range(0, 270)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        clk = 1'b0; reset = 1'b1;
        in_valid = 1'b0; ren_in_east = 1'b0; tick = 1'b0;
        in_core_x = 9'd0; in_core_y = 9'd0; in_axon = 8'd0; in_tick = 4'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_bus_row_range();
        test_full();
        test_stream();
        test_tick();
        test_wrap();
        test_async_reset();
        test_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_bus.md
# input_bus

Injects externally supplied spikes into the west edge of the neuromorphic core grid. It is the counterpart of the output bus: it accepts absolute (core x, core y, axon, tick offset) spikes over a valid/ready handshake and converts them to relative-routed packets. It buffers the packets in a first-word-fall-through FIFO and presents them to the column-0 router's west port using the grid's empty/ren read protocol. It also reports per-tick injection counts and drain status to the tick controller.

## Interface
- PACKET_WIDTH, 30, packet width
- DX_MSB / DX_LSB, 29 / 21, dx field (signed two's complement)
- DY_MSB / DY_LSB, 20 / 12, dy field (signed two's complement)
- NUM_AXONS, 256, axons per core; axon field width = clog2(NUM_AXONS)
- NUM_TICKS, 16, tick-offset field width = clog2(NUM_TICKS)
- FIFO_DEPTH, 8, packet buffer entries (power of two, ≥2)
- BUS_ROW, 0, grid row of the bus; the bus sits at x = −1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_core_x  in  DX_MSB-DX_LSB+1  destination core column, unsigned
- in_core_y  in  DY_MSB-DY_LSB+1  destination core row, unsigned
- in_axon  in  clog2(NUM_AXONS)  destination axon
- in_tick  in  clog2(NUM_TICKS)  tick offset
- in_valid  in  1  spike offered
- in_ready  out  1  bus can accept
- dout_east  out  PACKET_WIDTH  FIFO head packet to the router's din_west
- empty_out_east  out  1  FIFO empty, to the router's empty_in_west
- ren_in_east  in  1  router pop, from the router's ren_out_west
- tick  in  1  one-cycle tick pulse
- inject_count  out  16  packets popped since the last tick
- drained  out  1  FIFO empty
- range_error  out  1  sticky; a spike was dropped

## Operation
- Packet layout:
  - [DX_MSB:DX_LSB] = dx = in_core_x + 1.
  - [DY_MSB:DY_LSB] = dy = in_core_y − BUS_ROW.
  - Below DY_LSB: {in_axon, in_tick}, with in_tick in the low bits.
- Compute dx and dy one bit wider than the field. If dx > 2^(W−1)−1, or dy falls outside [−2^(W−1), 2^(W−1)−1], the spike is out of range:
  - The handshake still completes.
  - The spike is not written.
  - range_error sets and holds until reset.
- Accept when in_valid && in_ready. in_ready = !full, combinational from state only. It does not depend on ren_in_east the same cycle.
- Pop when ren_in_east && !empty. A ren_in_east while empty is ignored.
- Simultaneous in-range accept and pop: both occur and occupancy is unchanged.
- inject_count increments on each pop and wraps at 16 bits.
  - A tick pulse sets it to 0, or to 1 if a pop occurs the same cycle.
- drained = empty_out_east.
- FIFO state: read pointer, write pointer and occupancy counter of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - in_ready = 1
  - empty_out_east = 1
  - drained = 1
  - dout_east = 0 (storage cleared)
  - inject_count = 0
  - range_error = 0
- Reset mid-operation flushes all buffered packets immediately (asynchronous).
- Accept-to-visible latency is 1 cycle. A spike accepted in cycle N into an empty FIFO drives dout_east with empty_out_east = 0 in cycle N+1.
- First-word fall-through: dout_east always shows the head. After a pop in cycle N, the next entry, or empty_out_east = 1, appears in cycle N+1.
- Full: in_ready = 0 from the cycle after the FIFO_DEPTH-th write. It returns to 1 the cycle after a pop.
- range_error asserts the cycle after the offending accept.

## Test plan
- After reset, offer x=2, y=3, axon=0x15, tick=4 (BUS_ROW=0) -> next cycle empty_out_east=0 and dout_east = {9'd3, 9'd3, 8'h15, 4'd4}. Pulse ren_in_east -> empty returns to 1 the next cycle and inject_count=1.
- BUS_ROW=5, spike y=2 -> dy field = 9'h1FD (−3). Spike x=255 -> dropped, range_error=1, and empty_out_east stays 1.
- Write 8 spikes with no ren -> in_ready=0 after the 8th. A 9th in_valid is held off. One pop -> in_ready=1 the next cycle, and the 9th enters in FIFO order.
- Continuous valid and ren at occupancy 3 -> occupancy stays at 3 and packets emerge in input order. A ren while empty changes nothing.
- Pop on the same cycle as tick -> inject_count=1. Tick alone -> inject_count=0. 65536 pops -> wraps to 0.
- Assert reset with 5 entries buffered -> same cycle empty_out_east=1, in_ready=1, range_error=0.
